// File: rtl/mips_mult_div_if.sv
// Handshake and data bundle between pipeline control and the mips_mult_div unit.
// The master drives requests and operands; the slave returns status and HI/LO.
interface mips_mult_div_if;
    logic        signal_start;
    logic [1:0]  op;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;
    logic [31:0] write_data;
    logic        signal_mthi;
    logic        signal_mtlo;
    logic        signal_busy;
    logic        signal_done;
    logic        signal_div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output signal_start, op, read_data_1, read_data_2, write_data, signal_mthi, signal_mtlo,
        input  signal_busy, signal_done, signal_div_zero, hi, lo
    );

    modport slave (
        input  signal_start, op, read_data_1, read_data_2, write_data, signal_mthi, signal_mtlo,
        output signal_busy, signal_done, signal_div_zero, hi, lo
    );
endinterface

// File: rtl/mips_mult_div.sv
// Multi-cycle 32-bit multiply/divide unit with architectural HI/LO registers.
// Define MIPS_MULTDIV_DIV_EN to build the restoring divider for DIV/DIVU.
module mips_mult_div (
    input  logic           clk,
    input  logic           rst,
    mips_mult_div_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // 32 iteration cycles (count 0..31) then one write-back cycle at 32
    localparam logic [5:0] LAST_COUNT = 6'd32;

    state_t      state_r, state_s;
    logic [5:0]  count_r;
    logic        short_r;
    logic        zero_r;
    logic        sign_q_r;
    logic [31:0] operand_r;
    logic [63:0] work_r;
    logic [63:0] step_s;
    logic [32:0] mult_sum_s;
    logic [63:0] prod_s;
    logic [31:0] res_hi_s, res_lo_s;
    logic [31:0] hi_r, lo_r;
    logic        busy_r, done_r, div_zero_r;
    logic        is_div_s, is_signed_s, rs_neg_s, rt_neg_s;
    logic [31:0] rs_mag_s, rt_mag_s;
    logic        start_short_s, start_zero_s;
`ifdef MIPS_MULTDIV_DIV_EN
    logic        div_r;
    logic        sign_rem_r;
    logic [32:0] shift_s;
    logic [31:0] quo_s, rem_s;
`endif

    function automatic logic [31:0] abs_if_neg(input logic neg, input logic [31:0] value);
        abs_if_neg = neg ? (32'd0 - value) : value;
    endfunction

    // Decode the request: operand magnitudes and whether it finishes without iterating
    always_comb begin
        is_div_s    = bus.op[1];
        is_signed_s = bus.op[0];
        rs_neg_s    = is_signed_s & bus.read_data_1[31];
        rt_neg_s    = is_signed_s & bus.read_data_2[31];
        rs_mag_s    = abs_if_neg(rs_neg_s, bus.read_data_1);
        rt_mag_s    = abs_if_neg(rt_neg_s, bus.read_data_2);
`ifdef MIPS_MULTDIV_DIV_EN
        start_zero_s  = is_div_s & (bus.read_data_2 == 32'd0);
        start_short_s = start_zero_s;
`else
        start_zero_s  = 1'b0;
        start_short_s = is_div_s;
`endif
    end

    // One iteration: shift-add multiply (LSB first) or restoring divide (MSB first)
    always_comb begin
        mult_sum_s = {1'b0, work_r[63:32]} + (work_r[0] ? {1'b0, operand_r} : 33'd0);
`ifdef MIPS_MULTDIV_DIV_EN
        shift_s = {work_r[63:32], work_r[31]};
        if (div_r) begin
            // remainder after a successful trial subtract is below the divisor, so 32 bits hold it
            if (shift_s >= {1'b0, operand_r}) begin
                step_s = {shift_s[31:0] - operand_r, work_r[30:0], 1'b1};
            end else begin
                step_s = {shift_s[31:0], work_r[30:0], 1'b0};
            end
        end else begin
            step_s = {mult_sum_s, work_r[31:1]};
        end
`else
        step_s = {mult_sum_s, work_r[31:1]};
`endif
    end

    // Sign correction of the finished magnitude result
    always_comb begin
        prod_s = sign_q_r ? (64'd0 - work_r) : work_r;
`ifdef MIPS_MULTDIV_DIV_EN
        quo_s = abs_if_neg(sign_q_r, work_r[31:0]);
        rem_s = abs_if_neg(sign_rem_r, work_r[63:32]);
        if (div_r) begin
            res_hi_s = rem_s;
            res_lo_s = quo_s;
        end else begin
            res_hi_s = prod_s[63:32];
            res_lo_s = prod_s[31:0];
        end
`else
        res_hi_s = prod_s[63:32];
        res_lo_s = prod_s[31:0];
`endif
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.signal_start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (short_r || (count_r == LAST_COUNT)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            busy_r     <= (state_s != ST_IDLE);
            done_r     <= (state_s == ST_DONE);
            div_zero_r <= (state_s == ST_DONE) && zero_r;
        end
    end

    // Operand latch, iteration datapath and HI/LO registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r   <= 6'd0;
            short_r   <= 1'b0;
            zero_r    <= 1'b0;
            sign_q_r  <= 1'b0;
            operand_r <= 32'd0;
            work_r    <= 64'd0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
`ifdef MIPS_MULTDIV_DIV_EN
            div_r      <= 1'b0;
            sign_rem_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.signal_start) begin
                        count_r   <= 6'd0;
                        short_r   <= start_short_s;
                        zero_r    <= start_zero_s;
                        sign_q_r  <= rs_neg_s ^ rt_neg_s;
                        operand_r <= is_div_s ? rt_mag_s : rs_mag_s;
                        work_r    <= {32'd0, (is_div_s ? rs_mag_s : rt_mag_s)};
`ifdef MIPS_MULTDIV_DIV_EN
                        div_r      <= is_div_s;
                        sign_rem_r <= rs_neg_s;
`endif
                    end else begin
                        if (bus.signal_mthi) hi_r <= bus.write_data;
                        if (bus.signal_mtlo) lo_r <= bus.write_data;
                    end
                end
                ST_RUN: begin
                    if (!short_r) begin
                        if (count_r == LAST_COUNT) begin
                            hi_r <= res_hi_s;
                            lo_r <= res_lo_s;
                        end else begin
                            work_r  <= step_s;
                            count_r <= count_r + 6'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.signal_busy     = busy_r;
    assign bus.signal_done     = done_r;
    assign bus.signal_div_zero = div_zero_r;
    assign bus.hi              = hi_r;
    assign bus.lo              = lo_r;
endmodule

// File: tb/tb_mips_mult_div.sv
// Directed plus randomized bench for mips_mult_div; expectations come from plain
// 64-bit arithmetic and the documented handshake timing.
module tb_mips_mult_div;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mips_mult_div_if bus ();

    mips_mult_div dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Issue one operation, wait for completion and compare against the arithmetic model.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit disturb, input bit mt_with_start);
        bit          is_div;
        bit          short_path;
        bit          dz;
        int          lat;
        logic [31:0] hi_e, lo_e;
        longint      sa, sb, q, r;
        logic [63:0] p;

        is_div = o[1];
`ifdef MIPS_MULTDIV_DIV_EN
        short_path = is_div && (b == 32'd0);
        dz         = short_path;
`else
        short_path = is_div;
        dz         = 1'b0;
`endif
        hi_e = exp_hi;
        lo_e = exp_lo;
        if (!short_path) begin
            if (!is_div) begin
                if (o[0]) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    p  = sa * sb;
                end else begin
                    p = {32'd0, a} * {32'd0, b};
                end
                hi_e = p[63:32];
                lo_e = p[31:0];
            end else begin
                if (o[0]) begin
                    sa   = longint'($signed(a));
                    sb   = longint'($signed(b));
                    q    = sa / sb;
                    r    = sa % sb;
                    lo_e = q[31:0];
                    hi_e = r[31:0];
                end else begin
                    lo_e = a / b;
                    hi_e = a % b;
                end
            end
        end

        @(negedge clk);
        bus.signal_start = 1'b1;
        bus.op           = o;
        bus.read_data_1  = a;
        bus.read_data_2  = b;
        if (mt_with_start) begin
            bus.signal_mthi = 1'b1;
            bus.signal_mtlo = 1'b1;
            bus.write_data  = 32'hDEADBEEF;
        end
        @(posedge clk);
        #1;
        bus.signal_start = 1'b0;
        bus.signal_mthi  = 1'b0;
        bus.signal_mtlo  = 1'b0;

        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.signal_done) begin
                lat = i;
                break;
            end
            if (disturb && i == 5) begin
                bus.signal_mthi = 1'b1;
                bus.signal_mtlo = 1'b1;
                bus.write_data  = 32'hFFFF0000;
            end
            if (disturb && i == 6) begin
                bus.signal_mthi = 1'b0;
                bus.signal_mtlo = 1'b0;
                check({tag, "_mt_in_run_hi"}, bus.hi, exp_hi);
                check({tag, "_mt_in_run_lo"}, bus.lo, exp_lo);
                check({tag, "_busy_mid"}, 32'(bus.signal_busy), 32'd1);
            end
            if (disturb && i == 10) begin
                bus.signal_start = 1'b1;
                bus.op           = 2'b00;
                bus.read_data_1  = 32'd9;
                bus.read_data_2  = 32'd9;
            end
            if (disturb && i == 11) begin
                bus.signal_start = 1'b0;
            end
        end

        check({tag, "_latency"}, 32'(lat), (short_path ? 32'd1 : 32'd33));
        check({tag, "_hi"}, bus.hi, hi_e);
        check({tag, "_lo"}, bus.lo, lo_e);
        check({tag, "_div_zero"}, 32'(bus.signal_div_zero), 32'(dz));
        check({tag, "_busy_done"}, 32'(bus.signal_busy), 32'd1);
        exp_hi = hi_e;
        exp_lo = lo_e;

        @(posedge clk);
        #1;
        check({tag, "_done_single"}, 32'(bus.signal_done), 32'd0);
        check({tag, "_busy_idle"}, 32'(bus.signal_busy), 32'd0);
    endtask

    task automatic mt_write(input string tag, input bit wr_hi, input bit wr_lo, input logic [31:0] data);
        @(negedge clk);
        bus.signal_mthi = wr_hi;
        bus.signal_mtlo = wr_lo;
        bus.write_data  = data;
        @(posedge clk);
        #1;
        bus.signal_mthi = 1'b0;
        bus.signal_mtlo = 1'b0;
        if (wr_hi) exp_hi = data;
        if (wr_lo) exp_lo = data;
        check({tag, "_hi"}, bus.hi, exp_hi);
        check({tag, "_lo"}, bus.lo, exp_lo);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        bit          done_seen;

        n_pass  = 0;
        n_total = 0;
        exp_hi  = 32'd0;
        exp_lo  = 32'd0;
        rst              = 1'b1;
        bus.signal_start = 1'b0;
        bus.op           = 2'b00;
        bus.read_data_1  = 32'd0;
        bus.read_data_2  = 32'd0;
        bus.write_data   = 32'd0;
        bus.signal_mthi  = 1'b0;
        bus.signal_mtlo  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_hi", bus.hi, 32'd0);
        check("reset_lo", bus.lo, 32'd0);
        check("reset_busy", 32'(bus.signal_busy), 32'd0);
        check("reset_done", 32'(bus.signal_done), 32'd0);
        check("reset_div_zero", 32'(bus.signal_div_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("multu_ff", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        check("multu_ff_hi_const", bus.hi, 32'hFFFFFFFE);
        check("multu_ff_lo_const", bus.lo, 32'h00000001);

        run_op("mult_m3x5", 2'b01, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b0);
        check("mult_m3x5_lo_const", bus.lo, 32'hFFFFFFF1);

        run_op("div_m7d2", 2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
`ifdef MIPS_MULTDIV_DIV_EN
        check("div_m7d2_lo_const", bus.lo, 32'hFFFFFFFD);
`endif

        mt_write("mthi", 1'b1, 1'b0, 32'hAAAA5555);
        mt_write("mtlo", 1'b0, 1'b1, 32'h12345678);
        mt_write("mt_both", 1'b1, 1'b1, 32'h0BADF00D);
        mt_write("mt_hi11", 1'b1, 1'b0, 32'h00000011);
        mt_write("mt_lo22", 1'b0, 1'b1, 32'h00000022);

        run_op("divu_by0", 2'b10, 32'd100, 32'd0, 1'b0, 1'b1);
        run_op("divu_100d3", 2'b10, 32'd100, 32'd3, 1'b0, 1'b0);
        run_op("multu_7x6", 2'b00, 32'd7, 32'd6, 1'b1, 1'b0);
        check("multu_7x6_lo_const", bus.lo, 32'd42);
        run_op("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);

        // Asynchronous abort in the middle of an iterating operation.
        mt_write("pre_abort", 1'b1, 1'b1, 32'h5A5A5A5A);
`ifdef MIPS_MULTDIV_DIV_EN
        rop = 2'b10;
`else
        rop = 2'b00;
`endif
        @(negedge clk);
        bus.signal_start = 1'b1;
        bus.op           = rop;
        bus.read_data_1  = 32'd1000;
        bus.read_data_2  = 32'd7;
        @(posedge clk);
        #1;
        bus.signal_start = 1'b0;
        repeat (15) @(posedge clk);
        #4;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(bus.signal_busy), 32'd0);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        check("abort_done", 32'(bus.signal_done), 32'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        done_seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.signal_done) done_seen = 1'b1;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        run_op("divu_1000d7", 2'b10, 32'd1000, 32'd7, 1'b0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 300));
            run_op($sformatf("rand%0d", k), ro, ra, rb, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
